// File: rtl/qbert_pkg.sv
// Shared types and constants for the Qbert pyramid colour tracker.
// Also holds a one-hot test used when a landing is accepted.
package qbert_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_PAUSED,
    ST_CHECK,
    ST_CLEARED
  } tracker_state_t;

  typedef enum logic [1:0] {
    SET_ONCE = 2'd0,
    TOGGLE   = 2'd1
  } level_mode_t;

  localparam int unsigned N_CUBES_C      = 28;
  localparam int unsigned SCORE_PER_CUBE = 25;
  localparam int unsigned LEVEL_BONUS    = 1000;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [N_CUBES_C-1:0] v);
    return (v != '0) && ((v & (v - {{(N_CUBES_C-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/cube_color_tracker_popcount28.sv
// Combinational population count of the 28-bit pyramid colour vector.
module popcount28 (
  input  logic [27:0] bits_i,
  output logic [4:0]  count_o
);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < 28; i++) begin
      count_o = count_o + 5'(bits_i[i]);
    end
  end

endmodule

// File: rtl/cube_color_tracker.sv
// Pyramid top-colour tracker: applies Qbert landings, counts coloured cubes, flags completion.
// Optional scoring (score / e_score_clr ports) is built when CUBE_SCORE_EN is defined.
module cube_color_tracker
  import qbert_pkg::*;
#(
  parameter int unsigned N_CUBES = N_CUBES_C,
  parameter int unsigned COUNT_W = 5
) (
  input  logic               CLK_33,
  input  logic               reset,
  input  logic               e_start_qb,
  input  logic               e_pause_qb,
  input  logic               e_resume_qb,
  input  logic [1:0]         e_level_mode,
  input  logic               done_move_qb,
  input  logic [N_CUBES-1:0] position_qb,
  output logic [N_CUBES-1:0] color_state,
  output logic [COUNT_W-1:0] n_colored,
  output logic               level_done,
  output logic               bad_pos,
`ifdef CUBE_SCORE_EN
  input  logic               e_score_clr,
  output logic [15:0]        score,
`endif
  output logic               busy
);

  tracker_state_t     state_q;
  logic [N_CUBES-1:0] color_q;
  logic [COUNT_W-1:0] n_colored_q;
  logic               level_done_q;
  logic               bad_pos_q;
  logic               busy_q;
  logic               pause_pend_q;
  logic               rise_q;

  logic [4:0]         pop_w;
  logic               full_w;
  logic               onehot_w;
  logic               multi_w;
  logic               toggle_w;

  popcount28 u_popcount28 (
    .bits_i  (color_q),
    .count_o (pop_w)
  );

  assign full_w   = (COUNT_W'(pop_w) == COUNT_W'(N_CUBES));
  assign onehot_w = is_onehot(position_qb);
  assign multi_w  = (position_qb != '0) && !onehot_w;
  assign toggle_w = (e_level_mode == TOGGLE);

  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      color_q      <= '0;
      n_colored_q  <= '0;
      level_done_q <= 1'b0;
      bad_pos_q    <= 1'b0;
      busy_q       <= 1'b0;
      pause_pend_q <= 1'b0;
      rise_q       <= 1'b0;
    end else begin
      level_done_q <= 1'b0;
      bad_pos_q    <= 1'b0;
      if (e_start_qb) begin
        state_q      <= ST_PLAY;
        color_q      <= '0;
        n_colored_q  <= '0;
        pause_pend_q <= 1'b0;
        rise_q       <= 1'b0;
        busy_q       <= 1'b1;
      end else begin
        case (state_q)
          ST_PLAY: begin
            if (done_move_qb && onehot_w) begin
              color_q      <= toggle_w ? (color_q ^ position_qb) : (color_q | position_qb);
              rise_q       <= ((color_q & position_qb) == '0);
              // A pause in the landing cycle is held until the CHECK cycle retires.
              pause_pend_q <= e_pause_qb;
              state_q      <= ST_CHECK;
              busy_q       <= 1'b1;
            end else begin
              bad_pos_q <= done_move_qb && multi_w;
              if (e_pause_qb) begin
                state_q <= ST_PAUSED;
                busy_q  <= 1'b0;
              end
            end
          end
          ST_CHECK: begin
            n_colored_q  <= COUNT_W'(pop_w);
            pause_pend_q <= 1'b0;
            if (full_w) begin
              level_done_q <= 1'b1;
              state_q      <= ST_CLEARED;
              busy_q       <= 1'b0;
            end else if (pause_pend_q || e_pause_qb) begin
              state_q <= ST_PAUSED;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_PLAY;
              busy_q  <= 1'b1;
            end
          end
          ST_PAUSED: begin
            if (e_resume_qb) begin
              state_q <= ST_PLAY;
              busy_q  <= 1'b1;
            end
          end
          ST_IDLE, ST_CLEARED: begin
            busy_q <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CUBE_SCORE_EN
  logic [15:0] score_q;
  logic [16:0] score_sum_w;

  always_comb begin
    score_sum_w = {1'b0, score_q}
                + (rise_q ? 17'(SCORE_PER_CUBE) : '0)
                + (full_w ? 17'(LEVEL_BONUS) : '0);
  end

  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      score_q <= '0;
    end else if (e_score_clr) begin
      score_q <= '0;
    end else if (state_q == ST_CHECK && !e_start_qb) begin
      score_q <= score_sum_w[16] ? '1 : score_sum_w[15:0];
    end
  end

  assign score = score_q;
`endif

  assign color_state = color_q;
  assign n_colored   = n_colored_q;
  assign level_done  = level_done_q;
  assign bad_pos     = bad_pos_q;
  assign busy        = busy_q;

endmodule
